// File: rtl/dbg_port_master.sv
// Host-side sequencer for the RI5CY debug slave port: one outstanding
// read/write per command, with a grant/rvalid timeout and a valid/ready response.
module dbg_port_master #(
  parameter int DBG_ADDR_WIDTH = 15,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [DBG_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]               cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      debug_req_o,
  input  logic                      debug_gnt_i,
  input  logic                      debug_rvalid_i,
  output logic [DBG_ADDR_WIDTH-1:0] debug_addr_o,
  output logic                      debug_we_o,
  output logic [31:0]               debug_wdata_o,
  input  logic [31:0]               debug_rdata_i,
  output logic                      busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RV, RESP} state_t;

  state_t                    state_q;
  logic                      debugReq_q;
  logic [DBG_ADDR_WIDTH-1:0] debugAddr_q;
  logic                      debugWe_q;
  logic [31:0]               debugWdata_q;
  logic [31:0]               rspRdata_q;
  logic                      rspErr_q;
  logic [15:0]               timeoutCnt_q;
  logic                      cntLast_d;

  // The counter is shared by REQ and WAIT_RV, so the budget covers the whole access.
  assign cntLast_d = (timeoutCnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Single FSM; completion is tested before the timeout so a late-but-in-budget
  // grant or rvalid always wins over the abort.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      debugReq_q   <= 1'b0;
      debugAddr_q  <= '0;
      debugWe_q    <= 1'b0;
      debugWdata_q <= '0;
      rspRdata_q   <= '0;
      rspErr_q     <= 1'b0;
      timeoutCnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            debugAddr_q  <= cmd_addr_i;
            debugWe_q    <= cmd_we_i;
            debugWdata_q <= cmd_wdata_i;
            debugReq_q   <= 1'b1;
            timeoutCnt_q <= '0;
            state_q      <= REQ;
          end
        end
        REQ: begin
          timeoutCnt_q <= timeoutCnt_q + 16'd1;
          if (debug_gnt_i) begin
            debugReq_q <= 1'b0;
            state_q    <= WAIT_RV;
          end else if (cntLast_d) begin
            debugReq_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b1;
            state_q    <= RESP;
          end
        end
        WAIT_RV: begin
          timeoutCnt_q <= timeoutCnt_q + 16'd1;
          if (debug_rvalid_i) begin
            rspRdata_q <= debugWe_q ? 32'h0 : debug_rdata_i;
            rspErr_q   <= 1'b0;
            state_q    <= RESP;
          end else if (cntLast_d) begin
            rspRdata_q <= '0;
            rspErr_q   <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign busy_o        = (state_q != IDLE);
  assign rsp_rdata_o   = rspRdata_q;
  assign rsp_err_o     = rspErr_q;
  assign debug_req_o   = debugReq_q;
  assign debug_addr_o  = debugAddr_q;
  assign debug_we_o    = debugWe_q;
  assign debug_wdata_o = debugWdata_q;

endmodule
